// File: rtl/rom_arb_pkg.sv
// Shared helpers for the ROM port arbiter: index-width derivation and parameter range checks.
package rom_arb_pkg;

  localparam int unsigned MinNumReq = 2;
  localparam int unsigned MaxNumReq = 16;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

  // Requester index width; never zero so a port of width id_bits() is always legal.
  function automatic int unsigned id_bits(input int unsigned n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  function automatic bit num_req_ok(input int unsigned n);
    return (n >= MinNumReq) && (n <= MaxNumReq);
  endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Requester/response bundle of the ROM port arbiter; the arbiter uses the slave modport.
interface rom_port_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_BITS  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_BITS    = 2
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_BITS-1:0]           rsp_id;
  logic [DATA_WIDTH-1:0]        rsp_data;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr_i, wrapping.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_BITS = id_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_BITS-1:0] ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_BITS-1:0] idx_o
);

  logic               found;
  logic [ID_BITS:0]   cand;

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // One extra bit holds ptr+k before the explicit wrap, so the index stays < NUM_REQ.
      cand = {1'b0, ptr_i} + (ID_BITS + 1)'(k);
      if (cand >= (ID_BITS + 1)'(NUM_REQ)) begin
        cand = cand - (ID_BITS + 1)'(NUM_REQ);
      end
      if (!found && req_i[cand[ID_BITS-1:0]]) begin
        found = 1'b1;
        idx_o = cand[ID_BITS-1:0];
      end
    end
    grant_o = '0;
    if (found && en_i) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous-read ROM port among NUM_REQ requesters with round-robin grant
// and a single response stage matching the ROM's one-cycle read latency.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_BITS  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_BITS    = id_bits(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  rom_port_arbiter_if.slave     bus,
  output logic                  rom_en,
  output logic [ADDR_BITS-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  if (!num_req_ok(NUM_REQ) || (ID_BITS != id_bits(NUM_REQ))) begin : g_bad_param
    $error("rom_port_arbiter: NUM_REQ must be 2..16 and ID_BITS must equal clog2(NUM_REQ)");
  end

  logic               s1_valid_q, s1_valid_d;
  logic [ID_BITS-1:0] s1_id_q, s1_id_d;
  logic [ID_BITS-1:0] rr_ptr_q, rr_ptr_d;

  logic               can_issue;
  logic               issue;
  logic [NUM_REQ-1:0] grant;
  logic [ID_BITS-1:0] win_idx;

  // A retiring response frees the stage in the same cycle, so issue can follow back-to-back.
  assign can_issue = !s1_valid_q || bus.rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_rr_arbiter (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (can_issue && reset),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

  assign issue         = |grant;
  assign bus.req_ready = grant;
  assign rom_en        = issue;

  always_comb begin
    rom_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        rom_addr = bus.req_addr[i*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (issue) begin
      s1_valid_d = 1'b1;
      s1_id_d    = win_idx;
      rr_ptr_d   = (win_idx == ID_BITS'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (s1_valid_q && bus.rsp_ready) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // The ROM's address register holds while rom_en is low, keeping rsp_data stable in a stall.
  assign bus.rsp_valid = s1_valid_q;
  assign bus.rsp_id    = s1_id_q;
  assign bus.rsp_data  = rom_data;

endmodule
